// File: rtl/memory_game_round_ctrl_pkg.sv
// memory_game_defs: shared definitions for the memory game round controller.
// Holds the FSM state encoding, the datapath widths, the percent scale factor,
// the divider geometry and a saturating increment helper used by the score
// counters.
package memory_game_defs;

  localparam int PAT_W     = 10;   // pattern / switch width
  localparam int SCORE_W   = 7;    // score and percent width
  localparam int PCT_SCALE = 100;  // percent = PCT_SCALE * correct / total

  // Divider geometry: 99*100 fits in 14 bits, 99+99 fits in 8 bits.
  localparam int NUM_W     = 14;
  localparam int DEN_W     = 8;
  localparam int QUO_W     = 7;
  localparam int DIV_STEPS = 14;   // one quotient bit per cycle

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHOW   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_CALC   = 3'd5,
    ST_RESULT = 3'd6
  } state_t;

  // Increment that sticks at limit instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] limit);
    return (value >= limit) ? limit : value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/memory_game_pct_div.sv
// memory_game_pct_div: serial restoring divider for the percent-correct value.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   start         one-cycle pulse: latch num/den and begin dividing
//   num[13:0]     dividend (correct * 100)
//   den[7:0]      divisor (correct + incorrect)
//   quo[6:0]      quotient, valid while done is high and held afterwards
//   done          one-cycle pulse when the quotient is complete
// The first quotient bit is produced in the start cycle itself, so the
// remaining 13 bits follow on the next 13 cycles and done is seen by the
// consumer exactly DIV_STEPS cycles after start.
module memory_game_pct_div
  import memory_game_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [QUO_W-1:0] quo,
  output logic             done
);

  logic [DEN_W-1:0] rem;
  logic [NUM_W-1:0] quo_sr;
  logic [DEN_W-1:0] den_q;
  logic [3:0]       step_cnt;
  logic             running;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  function automatic logic [DEN_W+NUM_W-1:0] div_step(input logic [DEN_W-1:0] r,
                                                      input logic [NUM_W-1:0] q,
                                                      input logic [DEN_W-1:0] d);
    logic [DEN_W:0] trial;
    trial = {r, q[NUM_W-1]};
    if (trial >= {1'b0, d})
      return {DEN_W'(trial - {1'b0, d}), q[NUM_W-2:0], 1'b1};
    else
      return {trial[DEN_W-1:0], q[NUM_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      rem      <= '0;
      quo_sr   <= '0;
      den_q    <= '0;
      step_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quo_sr} <= div_step('0, num, den);
        den_q         <= den;
        step_cnt      <= 4'd1;
        running       <= 1'b1;
      end else if (running) begin
        {rem, quo_sr} <= div_step(rem, quo_sr, den_q);
        step_cnt      <= step_cnt + 4'd1;
        if (step_cnt == 4'(DIV_STEPS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // Percent never exceeds 100; clamp anyway so stray high bits cannot alias.
  assign quo = (|quo_sr[NUM_W-1:QUO_W]) ? '1 : quo_sr[QUO_W-1:0];

endmodule

// File: rtl/memory_game_round_ctrl.sv
// memory_game_round_ctrl: round sequencer for the memory game.
// Captures a random pattern, shows it for SHOW_TICKS display ticks, waits for
// the player's guess, scores it and computes percent-correct serially.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   tick             display timebase pulse (counted only while showing)
//   start            new game: clears scores, begins a round from any state
//   submit           player guess on sw is ready (honoured only while waiting)
//   next             begin the next round (honoured only in the result state)
//   sw[9:0]          player guess
//   rand_val[9:0]    LFSR value captured when a round loads
//   led[9:0]         pattern while showing, otherwise 0
//   correct[6:0]     correct rounds, saturating at SCORE_MAX
//   incorrect[6:0]   incorrect rounds, saturating at SCORE_MAX
//   percent[6:0]     floor(100*correct/(correct+incorrect))
//   pct_valid        percent reflects the current scores
//   busy             a round is in progress
//   state[2:0]       encoded FSM state
module memory_game_round_ctrl
  import memory_game_defs::*;
#(
  parameter int SHOW_TICKS = 3,
  parameter int SCORE_MAX  = 99
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               submit,
  input  logic               next,
  input  logic [PAT_W-1:0]   sw,
  input  logic [PAT_W-1:0]   rand_val,
  output logic [PAT_W-1:0]   led,
  output logic [SCORE_W-1:0] correct,
  output logic [SCORE_W-1:0] incorrect,
  output logic [SCORE_W-1:0] percent,
  output logic               pct_valid,
  output logic               busy,
  output logic [2:0]         state
);

  localparam int TICK_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam logic [TICK_W-1:0]  LAST_TICK = TICK_W'(SHOW_TICKS - 1);
  localparam logic [SCORE_W-1:0] SAT      = SCORE_W'(SCORE_MAX);

  state_t              st;
  logic [PAT_W-1:0]    pattern;
  logic [PAT_W-1:0]    guess;
  logic [TICK_W-1:0]   tick_cnt;

  logic [PAT_W-1:0]    load_pat;
  logic                hit;
  logic [SCORE_W-1:0]  corr_next;
  logic [SCORE_W-1:0]  inc_next;
  logic                div_start;
  logic [NUM_W-1:0]    div_num;
  logic [DEN_W-1:0]    div_den;
  logic [QUO_W-1:0]    div_quo;
  logic                div_done;
  logic                den_zero;

  // A zero pattern would leave the display dark, so substitute a single lit LED.
  assign load_pat = (rand_val == '0) ? PAT_W'(1) : rand_val;

  // The divider is launched in CHECK, the same cycle the scores update, so its
  // operands are taken from the post-update score values.
  assign hit       = (guess == pattern);
  assign corr_next = hit ? sat_inc(correct, SAT) : correct;
  assign inc_next  = hit ? incorrect : sat_inc(incorrect, SAT);
  assign div_start = (st == ST_CHECK);
  assign div_num   = NUM_W'(corr_next) * NUM_W'(PCT_SCALE);
  assign div_den   = DEN_W'(corr_next) + DEN_W'(inc_next);
  assign den_zero  = (correct == '0) && (incorrect == '0);

  memory_game_pct_div u_pct_div (
    .clock (clock),
    .reset (reset),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .quo   (div_quo),
    .done  (div_done)
  );

  // Round FSM with registered outputs; start overrides every other request.
  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= ST_IDLE;
      pattern   <= '0;
      guess     <= '0;
      tick_cnt  <= '0;
      led       <= '0;
      correct   <= '0;
      incorrect <= '0;
      percent   <= '0;
      pct_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      st        <= ST_LOAD;
      busy      <= 1'b1;
      led       <= '0;
      correct   <= '0;
      incorrect <= '0;
      percent   <= '0;
      pct_valid <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: ;
        ST_LOAD: begin
          pattern  <= load_pat;
          led      <= load_pat;
          tick_cnt <= '0;
          st       <= ST_SHOW;
        end
        ST_SHOW: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              led <= '0;
              st  <= ST_WAIT;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (submit) begin
            guess <= sw;
            st    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          correct   <= corr_next;
          incorrect <= inc_next;
          pct_valid <= 1'b0;
          st        <= ST_CALC;
        end
        ST_CALC: begin
          if (div_done) begin
            percent   <= den_zero ? '0 : div_quo;
            pct_valid <= 1'b1;
            busy      <= 1'b0;
            st        <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (next) begin
            busy <= 1'b1;
            st   <= ST_LOAD;
          end
        end
        default: begin
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_memory_game_round_ctrl.sv
// tb_memory_game_round_ctrl: self-checking bench for memory_game_round_ctrl.
// A round-level behavioural model tracks what every output must be each cycle;
// directed rounds add literal expectations for scores, percent and latency.
module tb_memory_game_round_ctrl;
  import memory_game_defs::*;

  localparam int SHOW_TICKS = 3;
  localparam int SCORE_MAX  = 99;

  logic       clock = 1'b0;
  logic       reset, tick, start, submit, next;
  logic [9:0] sw, rand_val;
  logic [9:0] led;
  logic [6:0] correct, incorrect, percent;
  logic       pct_valid, busy;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  memory_game_round_ctrl #(.SHOW_TICKS(SHOW_TICKS), .SCORE_MAX(SCORE_MAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .submit    (submit),
    .next      (next),
    .sw        (sw),
    .rand_val  (rand_val),
    .led       (led),
    .correct   (correct),
    .incorrect (incorrect),
    .percent   (percent),
    .pct_valid (pct_valid),
    .busy      (busy),
    .state     (state)
  );

  // Round-level model: phase name, pattern, tick count, scores and a plain
  // arithmetic percent computed when the 14-cycle calculation ends.
  state_t     m_state;
  logic [9:0] m_pat, m_guess;
  int         m_ticks, m_c, m_i, m_pct, m_left;
  bit         m_valid;
  bit         m_ready = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_state = ST_IDLE; m_pat = '0; m_guess = '0; m_ticks = 0;
      m_c = 0; m_i = 0; m_pct = 0; m_valid = 1'b0; m_left = 0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      if (start) begin
        m_c = 0; m_i = 0; m_pct = 0; m_valid = 1'b0;
        m_state = ST_LOAD;
      end else begin
        case (m_state)
          ST_LOAD: begin
            m_pat   = (rand_val == 10'd0) ? 10'd1 : rand_val;
            m_ticks = 0;
            m_state = ST_SHOW;
          end
          ST_SHOW: if (tick) begin
            m_ticks++;
            if (m_ticks == SHOW_TICKS) m_state = ST_WAIT;
          end
          ST_WAIT: if (submit) begin
            m_guess = sw;
            m_state = ST_CHECK;
          end
          ST_CHECK: begin
            if (m_guess == m_pat) m_c = (m_c + 1 > SCORE_MAX) ? SCORE_MAX : m_c + 1;
            else                  m_i = (m_i + 1 > SCORE_MAX) ? SCORE_MAX : m_i + 1;
            m_valid = 1'b0;
            m_left  = 14;
            m_state = ST_CALC;
          end
          ST_CALC: begin
            m_left--;
            if (m_left == 0) begin
              m_pct   = (m_c + m_i == 0) ? 0 : (100 * m_c) / (m_c + m_i);
              m_valid = 1'b1;
              m_state = ST_RESULT;
            end
          end
          ST_RESULT: if (next) m_state = ST_LOAD;
          default: ;
        endcase
      end
    end
  end

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge clock) begin
    logic [9:0] exp_led;
    logic       exp_busy;
    if (m_ready) begin
      exp_led  = (m_state == ST_SHOW) ? m_pat : 10'd0;
      exp_busy = m_state inside {ST_LOAD, ST_SHOW, ST_WAIT, ST_CHECK, ST_CALC};
      tests_run++;
      if ({state, led, correct, incorrect, percent, pct_valid, busy} !==
          {m_state, exp_led, 7'(m_c), 7'(m_i), 7'(m_pct), m_valid, exp_busy}) begin
        tests_failed++;
        $display("[TB] FAIL model_cycle @%0t: got st=%0d led=%h c=%0d i=%0d pct=%0d v=%b busy=%b, expected st=%0d led=%h c=%0d i=%0d pct=%0d v=%b busy=%b",
                 $time, state, led, correct, incorrect, percent, pct_valid, busy,
                 m_state, exp_led, m_c, m_i, m_pct, m_valid, exp_busy);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one-cycle pulses from a negedge; returns at the following negedge.
  task automatic apply_stimulus(input bit st, input bit sb, input bit nx, input bit tk);
    start = st; submit = sb; next = nx; tick = tk;
    @(negedge clock);
    start = 1'b0; submit = 1'b0; next = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Three tick pulses with gaps; SHOW must last exactly until the third.
  task automatic show_phase();
    for (int k = 1; k <= SHOW_TICKS; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (k < SHOW_TICKS) begin
        check_output("show_held", state, ST_SHOW);
        idle(1);
      end
    end
    check_output("show_exit_state", state, ST_WAIT);
    check_output("show_exit_led", led, 10'd0);
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (state !== ST_RESULT && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check_output("submit_latency", lat, 15);
  endtask

  task automatic play_round(input bit use_start, input logic [9:0] pat,
                            input logic [9:0] guess);
    rand_val = pat;
    apply_stimulus(use_start, 1'b0, !use_start, 1'b0);
    check_output("load_state", state, ST_LOAD);
    idle(1);
    check_output("show_led", led, pat);
    show_phase();
    sw = guess;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    wait_result();
  endtask

  task automatic check_scores(input string tag, input int c, input int i,
                              input int pct, input bit v);
    check_output({tag, "_correct"},   correct,   c);
    check_output({tag, "_incorrect"}, incorrect, i);
    check_output({tag, "_percent"},   percent,   pct);
    check_output({tag, "_pct_valid"}, pct_valid, v);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; submit = 1'b0; next = 1'b0;
    sw = '0; rand_val = '0;
    idle(2);
    reset = 1'b0;
    check_output("reset_state", state, ST_IDLE);
    check_output("reset_led", led, 10'd0);
    check_output("reset_busy", busy, 1'b0);
    check_scores("reset", 0, 0, 0, 1'b0);

    // Rounds 1-3: win, lose, lose.
    play_round(1'b1, 10'h2A5, 10'h2A5);
    check_scores("round1", 1, 0, 100, 1'b1);
    check_output("round1_busy", busy, 1'b0);
    play_round(1'b0, 10'h0F0, 10'h0F1);
    check_scores("round2", 1, 1, 50, 1'b1);
    play_round(1'b0, 10'h155, 10'h000);
    check_scores("round3", 1, 2, 33, 1'b1);

    // Zero pattern, plus submit/next during SHOW must be ignored.
    rand_val = 10'h000;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_output("zero_pat_led", led, 10'h001);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("submit_in_show", state, ST_SHOW);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("next_in_show", state, ST_SHOW);
    check_scores("show_ignored", 1, 2, 33, 1'b1);
    show_phase();
    sw = 10'h001;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    wait_result();
    check_scores("round4", 2, 2, 50, 1'b1);

    // Win until correct saturates, then win once more.
    for (int r = 0; r < 97; r++) play_round(1'b0, 10'(r * 7 + 3), 10'(r * 7 + 3));
    check_scores("sat_reach", 99, 2, 98, 1'b1);
    play_round(1'b0, 10'h3FF, 10'h3FF);
    check_scores("sat_hold", 99, 2, 98, 1'b1);

    // start in the middle of CALC aborts the round.
    rand_val = 10'h3C3;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    show_phase();
    sw = 10'h3C3;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    check_output("mid_calc_state", state, ST_CALC);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("abort_state", state, ST_LOAD);
    check_output("abort_busy", busy, 1'b1);
    check_scores("abort", 0, 0, 0, 1'b0);
    idle(1);
    show_phase();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    wait_result();
    check_scores("after_abort", 1, 0, 100, 1'b1);

    // Reset while the pattern is showing.
    rand_val = 10'h0AA;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_output("pre_reset_state", state, ST_SHOW);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_output("mid_reset_state", state, ST_IDLE);
    check_output("mid_reset_led", led, 10'd0);
    check_output("mid_reset_busy", busy, 1'b0);
    check_scores("mid_reset", 0, 0, 0, 1'b0);

    // start and submit together in WAIT: start wins, no score increment.
    play_round(1'b1, 10'h111, 10'h111);
    check_scores("pre_collide", 1, 0, 100, 1'b1);
    rand_val = 10'h222;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    show_phase();
    sw = 10'h222;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("collide_state", state, ST_LOAD);
    check_scores("collide", 0, 0, 0, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
